// File: rtl/tpuv2_ctrl.sv
// Memory-mapped sequencer for the DIM x DIM systolic matrix unit: host bus decode,
// multiply-pass state machine and busy/done/err/mode status register.
module tpuv2_ctrl #(
    parameter int unsigned DIM    = 8,
    parameter int unsigned BITS_C = 16,
    parameter int unsigned ADDRW  = 16,
    parameter int unsigned DATAW  = 64,
    parameter int unsigned CW     = 2,
    parameter logic [ADDRW-1:0] BASE_A    = ADDRW'('h100),
    parameter logic [ADDRW-1:0] BASE_B    = ADDRW'('h200),
    parameter logic [ADDRW-1:0] BASE_C    = ADDRW'('h300),
    parameter logic [ADDRW-1:0] CTRL_ADDR = ADDRW'('h400),
    parameter logic [ADDRW-1:0] STAT_ADDR = ADDRW'('h408)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_w,
    input  logic [ADDRW-1:0]         addr,
    input  logic [DATAW-1:0]         dataIn,
    output logic [DATAW-1:0]         dataOut,
    output logic                     c_rd_sel,
    output logic                     a_wr_en,
    output logic [$clog2(DIM)-1:0]   a_row,
    output logic                     a_en,
    output logic                     b_wr_en,
    output logic                     b_en,
    output logic                     c_wr_en,
    output logic [$clog2(DIM)-1:0]   c_row,
    output logic [$clog2(CW)-1:0]    c_word,
    output logic                     c_clr,
    output logic                     sa_en,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned RW   = $clog2(DIM);
    localparam int unsigned WW   = $clog2(CW);
    localparam int unsigned CNTW = $clog2(3 * DIM - 2);
    localparam logic [CNTW-1:0] LAST = CNTW'(3 * DIM - 3);

    if (DIM * 8 != DATAW || DIM * BITS_C != CW * DATAW || CW < 2) begin : g_bad_cfg
        $error("tpuv2_ctrl: inconsistent DIM/DATAW/CW/BITS_C");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            done_q, done_nxt;
    logic            err_q, err_nxt;
    logic            acc_q, acc_nxt;

    // Half-open region test [base, base + words*8), one extra bit to avoid wrap.
    function automatic logic in_region(input logic [ADDRW-1:0] a,
                                       input logic [ADDRW-1:0] base,
                                       input int unsigned words);
        logic [ADDRW:0] lo, hi, x;
        lo = {1'b0, base};
        hi = lo + (ADDRW + 1)'(words * 8);
        x  = {1'b0, a};
        return (x >= lo) && (x < hi);
    endfunction

    logic hit_a, hit_b, hit_c, ctrl_wr, stat_rd, region_acc, unused;

    assign hit_a      = in_region(addr, BASE_A, DIM);
    assign hit_b      = in_region(addr, BASE_B, DIM);
    assign hit_c      = in_region(addr, BASE_C, DIM * CW);
    assign ctrl_wr    = r_w && (addr[ADDRW-1:3] == CTRL_ADDR[ADDRW-1:3]);
    assign stat_rd    = !r_w && (addr[ADDRW-1:3] == STAT_ADDR[ADDRW-1:3]);
    assign region_acc = (r_w && (hit_a || hit_b)) || hit_c;
    assign busy       = (state == CLEAR) || (state == RUN);
    assign done       = done_q;
    assign unused     = ^dataIn[DATAW-1:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            acc_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
            acc_q  <= acc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = done_q;
        err_nxt   = err_q;
        acc_nxt   = acc_q;
        dataOut   = '0;
        c_rd_sel  = 1'b0;
        a_wr_en   = 1'b0;
        a_row     = '0;
        a_en      = 1'b0;
        b_wr_en   = 1'b0;
        b_en      = 1'b0;
        c_wr_en   = 1'b0;
        c_row     = '0;
        c_word    = '0;
        c_clr     = 1'b0;
        sa_en     = 1'b0;

        if (stat_rd) begin
            dataOut  = DATAW'({acc_q, err_q, done_q, busy});
            done_nxt = 1'b0;
        end
        if (ctrl_wr && dataIn[2]) err_nxt = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (r_w && hit_a) begin
                    a_wr_en = 1'b1;
                    a_row   = RW'((addr - BASE_A) >> 3);
                end
                if (r_w && hit_b) begin
                    b_wr_en = 1'b1;
                    b_en    = 1'b1;
                end
                if (hit_c) begin
                    c_wr_en  = r_w;
                    c_rd_sel = !r_w;
                    sa_en    = !r_w;
                    c_row    = RW'((addr - BASE_C) >> (3 + WW));
                    c_word   = WW'((addr - BASE_C) >> 3);
                end
                if (ctrl_wr && dataIn[0]) begin
                    acc_nxt   = dataIn[1];
                    done_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = dataIn[1] ? RUN : CLEAR;
                end
            end
            CLEAR: begin
                c_clr     = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                a_en  = 1'b1;
                b_en  = 1'b1;
                sa_en = 1'b1;
                // Last count sets done; wins over a same-cycle status-read clear.
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (busy && (region_acc || (ctrl_wr && dataIn[0]))) err_nxt = 1'b1;
    end
endmodule

// File: doc/tpuv2_ctrl.md
Name: tpuv2_ctrl

Overview:
Parametrised memory-mapped sequencer for the next-generation DIM x DIM systolic matrix unit. Decodes host bus accesses into write and read strobes for the A row memory, the B column FIFO and the C accumulator array. Runs the multiply pass through an explicit state machine and exposes busy, done and error status through a readable status register. Adds accumulate and overwrite modes, start-while-busy protection and bus-collision detection.

Parameters:
DIM, 8, array dimension (power of two, 2..32)
BITS_C, 16, accumulator width
ADDRW, 16, bus address width
DATAW, 64, bus data width; DIM*8 == DATAW required
CW, 2, bus words per C row; DIM*BITS_C == CW*DATAW, CW >= 2 power of two
BASE_A, 16'h100, A region base (DIM words, 8-byte stride)
BASE_B, 16'h200, B region base (DIM words)
BASE_C, 16'h300, C region base (DIM*CW words)
CTRL_ADDR, 16'h400, control register address
STAT_ADDR, 16'h408, status register address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
r_w  in  1  0 = read, 1 = write; access valid every cycle addr is in a decoded region
addr  in  ADDRW  byte address; bits [2:0] ignored
dataIn  in  DATAW  write data
dataOut  out  DATAW  status word when addr == STAT_ADDR and r_w == 0, else 0
c_rd_sel  out  1  1 = external mux drives dataOut from C
a_wr_en  out  1  A row write strobe
a_row  out  clog2(DIM)  A row index
a_en  out  1  A shift enable
b_wr_en  out  1  B push strobe
b_en  out  1  B shift enable
c_wr_en  out  1  C partial-row write strobe
c_row  out  clog2(DIM)  C row index
c_word  out  clog2(CW)  word within C row
c_clr  out  1  clear all accumulators
sa_en  out  1  systolic array MAC enable
busy  out  1  pass in progress
done  out  1  sticky pass-complete flag

Behaviour:
- States: IDLE, CLEAR, RUN, DONE. Reset: state IDLE; all outputs 0, including err and the internal counter.
- Decoding is combinational from addr, r_w and state. Region hit uses the half-open range [BASE, BASE + words*8).
- In IDLE or DONE:
  - A write: a_wr_en = 1; a_row = (addr-BASE_A)>>3.
  - B write: b_wr_en = 1; b_en = 1.
  - C write: c_wr_en = 1; c_row = (addr-BASE_C)>>(3+log2 CW); c_word = next lower bits.
  - C read: c_rd_sel = 1; c_row and c_word as for writes; sa_en = 1.
- Start: a write to CTRL_ADDR with dataIn[0] = 1 while in IDLE or DONE.
  - dataIn[1] = 1 selects accumulate mode; 0 selects overwrite mode.
  - Start clears done.
  - Overwrite mode goes to CLEAR; accumulate mode goes straight to RUN.
- CLEAR: exactly 1 cycle with c_clr = 1, then RUN.
- RUN: counter runs 0 .. 3*DIM-3, so RUN lasts 3*DIM-2 cycles. a_en, b_en and sa_en are 1 every RUN cycle.
  - On the last count, go to DONE.
  - c_clr and sa_en are never both 1.
- busy = 1 in CLEAR and RUN.
- DONE: done = 1, held until the next start or a status read.
  - A status read clears done on the following cycle. The read itself returns done = 1.
- Status word: bit0 busy, bit1 done, bit2 err, bit3 accumulate mode of the last start. Upper bits are 0.
- Access while busy:
  - A, B or C writes and C reads produce no strobes and set sticky err.
  - A CTRL start while busy is ignored and sets err.
  - Reads of STAT_ADDR are always honoured.
- err clears only on a CTRL write with dataIn[2] = 1. That write may also start a pass.
- Writes to CTRL with dataIn[0] = 0 change no state except the err clear.
- Addresses in no region, and reads of CTRL, are no-ops.
- rst asserted mid-pass: returns to IDLE on the next edge; all strobes drop; counter cleared.
- Same-cycle status read and DONE entry: done reads 0 that cycle, then 1.
- No timeout, no wraparound: the counter saturates by the state exit.

Test Plan:
1. Reset, then write 0x1_0000 to 16'h118 -> a_wr_en = 1, a_row = 3 that cycle; status reads 0x0.
2. Write 16'h320 (DIM = 8, CW = 2) -> c_wr_en = 1, c_row = 2, c_word = 0. Then read 16'h328 -> c_rd_sel = 1, c_row = 2, c_word = 1, sa_en = 1.
3. CTRL write 0x1, DIM = 8 -> c_clr high 1 cycle, then sa_en high exactly 22 cycles. busy high 23 cycles total. Status then reads 0x2, and reads 0x0 after that read.
4. CTRL write 0x3 -> no c_clr; busy high exactly 22 cycles. Status reads 0xA.
5. During RUN: write 16'h200, then CTRL 0x1 -> no b_wr_en; pass length unchanged; status bit2 = 1. CTRL write 0x4 after DONE -> err = 0.
6. Assert rst at RUN cycle 10 -> next cycle busy = 0, sa_en = 0, state IDLE. A fresh start still yields 22 RUN cycles.
